// File: rtl/time_set_ctrl_pkg.sv
// Shared types for the time-set controller: FSM state encoding, BCD digit
// types, the hour/minute wrap limits and the two-digit BCD increment.
package time_set_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t hi;
    bcd_t lo;
  } bcd2_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    LOAD     = 2'd3
  } state_t;

  localparam bcd2_t HOUR_MAX = '{hi: 4'd2, lo: 4'd3};
  localparam bcd2_t MIN_MAX  = '{hi: 4'd5, lo: 4'd9};

  // Advance a two-digit BCD value by one, wrapping to 00 after lim.
  function automatic bcd2_t bcd2_inc(input bcd2_t v, input bcd2_t lim);
    bcd2_t r;
    if (v == lim) begin
      r = '0;
    end else if (v.lo == 4'd9) begin
      r.hi = v.hi + 4'd1;
      r.lo = 4'd0;
    end else begin
      r.hi = v.hi;
      r.lo = v.lo + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Signal bundle between the time-set controller, the buttons/divider that
// feed it and the timer/display that consume its outputs.
interface time_set_ctrl_if;
  import time_set_pkg::*;

  logic       tick;
  logic       modeBtn;
  logic       incBtn;
  bcd_t       curHMSD;
  bcd_t       curHLSD;
  bcd_t       curMMSD;
  bcd_t       curMLSD;
  logic       load;
  bcd_t       ldHMSD;
  bcd_t       ldHLSD;
  bcd_t       ldMMSD;
  bcd_t       ldMLSD;
  logic       holdTime;
  logic       blinkHours;
  logic       blinkMins;
  logic [1:0] setState;

  modport master (
    output tick, modeBtn, incBtn, curHMSD, curHLSD, curMMSD, curMLSD,
    input  load, ldHMSD, ldHLSD, ldMMSD, ldMLSD,
    input  holdTime, blinkHours, blinkMins, setState
  );

  modport slave (
    input  tick, modeBtn, incBtn, curHMSD, curHLSD, curMMSD, curMLSD,
    output load, ldHMSD, ldHLSD, ldMMSD, ldMLSD,
    output holdTime, blinkHours, blinkMins, setState
  );

endinterface

// File: rtl/time_set_ctrl_btn_debounce.sv
// Button debouncer: accepts a new level after DEBOUNCE consecutive differing
// samples and emits a one-cycle press pulse on each accepted rising edge.
module btn_debounce #(
  parameter logic [19:0] DEBOUNCE = 20'd500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  logic [19:0] cnt;
  logic        level;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (raw == level) begin
        cnt <= '0;
      end else if (cnt >= DEBOUNCE - 20'd1) begin
        // This edge is the DEBOUNCE-th differing sample: accept the new level.
        cnt   <= '0;
        level <= raw;
        press <= raw;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set controller: two debounced buttons step through hour/minute edit
// states on a shadow copy of the time, then strobe it into the timer.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE = 20'd500000,
  parameter logic [5:0]  TIMEOUT  = 6'd30
) (
  input logic             clk,
  input logic             reset,
  time_set_ctrl_if.slave  bus
);

  logic   mode_ev;
  logic   inc_ev;
  state_t state;
  state_t state_nxt;
  logic [5:0] idle;
  logic   blink_phase;
  logic   blink_nxt;
  logic   in_set;
  logic   timed_out;
  bcd2_t  sh_hour;
  bcd2_t  sh_min;
  logic   load_pulse;
  logic   hold;
  logic   blink_h;
  logic   blink_m;

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_mode_db (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.modeBtn),
    .press (mode_ev)
  );

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_inc_db (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.incBtn),
    .press (inc_ev)
  );

  // Mode always takes precedence over inc; an event in the same cycle as the
  // timeout keeps the edit alive since it also restarts the idle count.
  function automatic state_t fsm_next(input state_t s, input logic m,
                                      input logic i, input logic to);
    state_t n;
    n = s;
    case (s)
      RUN:      if (m) n = SET_HOUR;
      SET_HOUR: if (m) n = SET_MIN; else if (!i && to) n = RUN;
      SET_MIN:  if (m) n = LOAD;    else if (!i && to) n = RUN;
      default:  n = RUN;
    endcase
    return n;
  endfunction

  assign in_set    = (state == SET_HOUR) || (state == SET_MIN);
  assign timed_out = in_set && (idle >= TIMEOUT);
  assign state_nxt = fsm_next(state, mode_ev, inc_ev, timed_out);
  assign blink_nxt = (state_nxt inside {SET_HOUR, SET_MIN}) &&
                     (blink_phase ^ (in_set && bus.tick));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      idle        <= '0;
      blink_phase <= 1'b0;
      sh_hour     <= '0;
      sh_min      <= '0;
      load_pulse  <= 1'b0;
      hold        <= 1'b0;
      blink_h     <= 1'b0;
      blink_m     <= 1'b0;
    end else begin
      state       <= state_nxt;
      blink_phase <= blink_nxt;
      load_pulse  <= (state_nxt == LOAD);
      hold        <= (state_nxt != RUN);
      blink_h     <= (state_nxt == SET_HOUR) && blink_nxt;
      blink_m     <= (state_nxt == SET_MIN) && blink_nxt;

      case (state)
        RUN: begin
          idle <= '0;
          if (mode_ev) begin
            sh_hour <= '{hi: bus.curHMSD, lo: bus.curHLSD};
            sh_min  <= '{hi: bus.curMMSD, lo: bus.curMLSD};
          end
        end
        SET_HOUR: begin
          if (mode_ev || inc_ev)
            idle <= '0;
          else if (bus.tick && idle != 6'h3f)
            idle <= idle + 6'd1;
          if (!mode_ev && inc_ev)
            sh_hour <= bcd2_inc(sh_hour, HOUR_MAX);
        end
        SET_MIN: begin
          if (mode_ev || inc_ev)
            idle <= '0;
          else if (bus.tick && idle != 6'h3f)
            idle <= idle + 6'd1;
          if (!mode_ev && inc_ev)
            sh_min <= bcd2_inc(sh_min, MIN_MAX);
        end
        default: idle <= '0;
      endcase
    end
  end

  assign bus.load       = load_pulse;
  assign bus.holdTime   = hold;
  assign bus.blinkHours = blink_h;
  assign bus.blinkMins  = blink_m;
  assign bus.setState   = state;
  assign bus.ldHMSD     = sh_hour.hi;
  assign bus.ldHLSD     = sh_hour.lo;
  assign bus.ldMMSD     = sh_min.hi;
  assign bus.ldMLSD     = sh_min.lo;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed and random button sessions compared to a
// time-of-day model; load strobes are checked by a scoreboard monitor.
module tb_time_set_ctrl;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  time_set_ctrl_if bus();

  time_set_ctrl #(.DEBOUNCE(20'd4), .TIMEOUT(6'd3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Model: 0 = running, 1 = editing hours, 2 = editing minutes.
  int m_state = 0;
  int m_hh    = 0;
  int m_mm    = 0;
  int cur_hh  = 0;
  int cur_mm  = 0;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] to_bcd(input int hh, input int mm);
    return 16'(((hh / 10) << 12) | ((hh % 10) << 8) | ((mm / 10) << 4) | (mm % 10));
  endfunction

  function automatic logic [15:0] ld_now();
    return {bus.ldHMSD, bus.ldHLSD, bus.ldMMSD, bus.ldMLSD};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name);
    check({name, "_state"},  int'(bus.setState), m_state);
    check({name, "_hold"},   int'(bus.holdTime), (m_state != 0) ? 1 : 0);
    check({name, "_shadow"}, int'(ld_now()), int'(to_bcd(m_hh, m_mm)));
    check({name, "_blink"},  int'({bus.blinkHours, bus.blinkMins}), 0);
    check({name, "_load"},   int'(bus.load), 0);
  endtask

  task automatic set_cur(input int hh, input int mm);
    cur_hh = hh;
    cur_mm = mm;
    {bus.curHMSD, bus.curHLSD, bus.curMMSD, bus.curMLSD} = to_bcd(hh, mm);
  endtask

  task automatic model_press(input bit m, input bit i);
    if (m) begin
      case (m_state)
        0: begin m_hh = cur_hh; m_mm = cur_mm; m_state = 1; end
        1: m_state = 2;
        default: begin exp_q.push_back(to_bcd(m_hh, m_mm)); m_state = 0; end
      endcase
    end else if (i) begin
      if (m_state == 1) m_hh = (m_hh + 1) % 24;
      else if (m_state == 2) m_mm = (m_mm + 1) % 60;
    end
  endtask

  // Hold the button(s) for 'hold' samples, then release long enough for the
  // debouncer to accept the low level again.
  task automatic press(input bit m, input bit i, input int hold);
    model_press(m, i);
    @(negedge clk);
    bus.modeBtn = m;
    bus.incBtn  = i;
    repeat (hold) @(negedge clk);
    bus.modeBtn = 1'b0;
    bus.incBtn  = 1'b0;
    repeat (DB + 3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && bus.load === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL load_unexpected: got ld=0x%04h, required no load", ld_now());
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (ld_now() != e) begin
          n_err++;
          $display("FAIL load_value: got 0x%04h, required 0x%04h", ld_now(), e);
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    bus.tick    = 1'b0;
    bus.modeBtn = 1'b0;
    bus.incBtn  = 1'b0;
    set_cur(0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_state("reset");

    // Single long mode press captures 13:47.
    set_cur(13, 47);
    press(1'b1, 1'b0, 6);
    check_state("capture_1347");

    // Finish that edit unchanged, then hour and minute wrap from 23:59.
    press(1'b1, 1'b0, DB);
    press(1'b1, 1'b0, DB);
    check_state("load_1347");
    set_cur(23, 59);
    press(1'b1, 1'b0, DB);
    press(1'b0, 1'b1, DB + 1);
    check_state("hour_wrap");
    press(1'b1, 1'b0, DB);
    press(1'b0, 1'b1, DB + 2);
    check_state("min_wrap");
    press(1'b1, 1'b0, DB);
    check_state("load_0000");

    // Minute wrap must not carry into hours.
    set_cur(10, 59);
    press(1'b1, 1'b0, DB);
    press(1'b1, 1'b0, DB);
    press(1'b0, 1'b1, DB);
    check_state("min_nocarry");
    press(1'b1, 1'b0, DB);

    // Full sequence from 06:04 ends in a single load of 07:05.
    set_cur(6, 4);
    press(1'b1, 1'b0, DB);
    press(1'b0, 1'b1, DB);
    press(1'b1, 1'b0, DB);
    press(1'b0, 1'b1, DB);
    press(1'b1, 1'b0, DB);
    check_state("load_0705");

    // Bouncing mode button never settles long enough to count.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k % 2 == 0) bus.modeBtn = ~bus.modeBtn;
    end
    bus.modeBtn = 1'b0;
    repeat (DB + 3) @(negedge clk);
    check_state("bounce");

    // Idle timeout out of minute edit, with blink toggling per tick.
    set_cur(4, 20);
    press(1'b1, 1'b0, DB);
    press(1'b1, 1'b0, DB);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
      check("timeout_blink", int'(bus.blinkMins), k % 2);
      check("timeout_hold_state", int'(bus.setState), 2);
    end
    @(negedge clk);
    m_state = 0;
    check_state("timeout_exit");

    // Reset while editing minutes clears everything.
    set_cur(17, 33);
    press(1'b1, 1'b0, DB);
    press(1'b1, 1'b0, DB);
    check_state("pre_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_state = 0;
    m_hh = 0;
    m_mm = 0;
    check_state("reset_setmin");

    // Mode and inc together in hour edit: mode wins, hours untouched.
    set_cur(8, 30);
    press(1'b1, 1'b0, DB);
    press(1'b1, 1'b1, DB + 1);
    check_state("mode_inc_same");
    press(1'b1, 1'b0, DB);
    check_state("load_0830");

    // Random sessions.
    for (int s = 0; s < 8; s++) begin
      for (int k = 0; k < 12; k++) begin
        int r;
        set_cur(int'($urandom_range(23)), int'($urandom_range(59)));
        r = int'($urandom_range(9));
        if (r == 0)     press(1'b1, 1'b1, DB + int'($urandom_range(4)));
        else if (r < 4) press(1'b1, 1'b0, DB + int'($urandom_range(4)));
        else            press(1'b0, 1'b1, DB + int'($urandom_range(4)));
        check_state("random");
      end
    end

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
